// File: rtl/cpu_defs.sv
// cpu_defs: shared opcode, T-state and width constants for the accumulator CPU
package cpu_defs;
  localparam int OPC_W = 4;
  localparam int T_LEN = 6;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
endpackage

// File: rtl/t_ring_counter.sv
// t_ring_counter: one-hot T1..T6 ring, rotates every enabled clock
module t_ring_counter import cpu_defs::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [T_LEN-1:0] t_state
);
  always_ff @(posedge clk)
    t_state <= reset ? T1 : en ? {t_state[T_LEN-2:0], t_state[T_LEN-1]} : t_state;
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: T-state decode and HLT logic; CTRL_JUMP_EN adds JMP/JZ via l_pc
module ctrl_sequencer import cpu_defs::*; #(
  parameter int               OPC_W   = cpu_defs::OPC_W,
  parameter int               T_LEN   = cpu_defs::T_LEN,
  parameter logic [OPC_W-1:0] HLT_OPC = cpu_defs::OP_HLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  output logic [T_LEN-1:0] t_state,
  output logic             ep, cp, lm,
  output logic             ce, li, ei,
  output logic             la, ea,
  output logic             lb, su, eu,
  output logic             lo,
  output logic             l_pc,
  output logic             halted
);
  logic [T_LEN-1:0] ring;
  logic lda, add, sub, out, mem, jump;
  t_ring_counter u_ring (.clk(clk), .reset(reset), .en(~halted), .t_state(ring));
  // the ring freezes while halted, so masking it gives the all-zero halted view
  assign t_state = halted ? '0 : ring;
  always_ff @(posedge clk)
    halted <= reset ? 1'b0 : halted | (ring[3] & (opcode == HLT_OPC));
  assign lda = opcode == OP_LDA;
  assign add = opcode == OP_ADD;
  assign sub = opcode == OP_SUB;
  assign out = opcode == OP_OUT;
  assign mem = lda | add | sub;
  always_comb begin
`ifdef CTRL_JUMP_EN
    jump = t_state[3] & ((opcode == OP_JMP) | ((opcode == OP_JZ) & zero_flag));
`else
    jump = 1'b0;
`endif
    ep   = t_state[0];
    cp   = t_state[1];
    li   = t_state[2];
    lm   = t_state[0] | (t_state[3] & mem);
    ce   = t_state[2] | (t_state[4] & mem);
    ei   = (t_state[3] & mem) | jump;
    la   = (t_state[4] & lda) | (t_state[5] & (add | sub));
    lb   = t_state[4] & (add | sub);
    eu   = t_state[5] & (add | sub);
    su   = t_state[5] & sub;
    ea   = t_state[3] & out;
    lo   = t_state[3] & out;
    l_pc = jump;
  end
endmodule
